serial_adder: RTL and testbench

SERIAL_ADDER -- requirements
Module: serial_adder

---
 rtl/serial_adder.sv | 137 +++++++++++++
 tb/tb_serial_adder.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder cell plus a carry flop, one operand bit pair per clock, LSB first.
// Latency: WIDTH cycles from the edge that accepts start to the done pulse.
// Backpressure: none; start is ignored while busy or in done, and sum/cout hold until the next completion.
module serial_adder #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);

   localparam int            CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] opa_q, opa_d;
   logic [WIDTH-1:0] opb_q, opb_d;
   logic [WIDTH-1:0] psum_q, psum_d;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic             carry_q, carry_d;
   logic             cout_q, cout_d;
   logic [CW-1:0]    cnt_q, cnt_d;

   logic             s_bit;
   logic             c_next;
   logic             last_bit;

   // The single full-adder cell working on the current LSBs and the carry flop
   assign s_bit    = opa_q[0] ^ opb_q[0] ^ carry_q;
   assign c_next   = (opa_q[0] & opb_q[0]) | (opa_q[0] & carry_q) | (opb_q[0] & carry_q);
   assign last_bit = (cnt_q == LAST);

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic: DONE is a single cycle and returns to IDLE unconditionally
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start) state_d = SHIFT;
         SHIFT:   if (last_bit) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Outputs decoded purely from the registered state
   always_comb begin
      busy = 1'b0;
      done = 1'b0;
      case (state_q)
         SHIFT:   busy = 1'b1;
         DONE:    done = 1'b1;
         default: ;
      endcase
   end

   // Datapath next-state: load on accepted start, shift one bit per SHIFT cycle,
   // and publish the result only on the edge that processes the last bit
   always_comb begin
      opa_d   = opa_q;
      opb_d   = opb_q;
      psum_d  = psum_q;
      carry_d = carry_q;
      cnt_d   = cnt_q;
      sum_d   = sum_q;
      cout_d  = cout_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               opa_d   = a;
               opb_d   = b;
               carry_d = cin;
               psum_d  = '0;
               cnt_d   = '0;
            end
         end
         SHIFT: begin
            opa_d   = opa_q >> 1;
            opb_d   = opb_q >> 1;
            carry_d = c_next;
            // new sum bit enters at the MSB; after WIDTH shifts bit 0 sits at the LSB
            psum_d  = WIDTH'({s_bit, psum_q} >> 1);
            cnt_d   = cnt_q + CW'(1);
            if (last_bit) begin
               sum_d  = psum_d;
               cout_d = c_next;
            end
         end
         default: ;
      endcase
   end

   // Datapath registers; reset clears everything so an aborted addition leaves no result
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         opa_q   <= '0;
         opb_q   <= '0;
         psum_q  <= '0;
         carry_q <= 1'b0;
         cnt_q   <= '0;
         sum_q   <= '0;
         cout_q  <= 1'b0;
      end else begin
         opa_q   <= opa_d;
         opb_q   <= opb_d;
         psum_q  <= psum_d;
         carry_q <= carry_d;
         cnt_q   <= cnt_d;
         sum_q   <= sum_d;
         cout_q  <= cout_d;
      end
   end

   assign sum  = sum_q;
   assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder at WIDTH=8.
// Reference: result = (a + b + cin) as a WIDTH+1-bit integer; last delivered result kept in m_sum/m_cout.
// Directed corner cases, mid-addition interference, async reset abort, back-to-back starts, random sums.
module tb_serial_adder;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         start;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         cin;
   logic         busy;
   logic         done;
   logic [W-1:0] sum;
   logic         cout;

   int checks = 0;
   int fails  = 0;

   // model of the last result the DUT should be presenting
   logic [W-1:0] m_sum;
   logic         m_cout;

   serial_adder #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .a     (a),
      .b     (b),
      .cin   (cin),
      .busy  (busy),
      .done  (done),
      .sum   (sum),
      .cout  (cout)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // One complete addition from IDLE; optionally pulses start with new operands at cycle inject_at
   task automatic run_add(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tc,
                          input int inject_at, input string tag);
      logic [W:0] full;
      int         lat;
      bit         busy_ok;
      bit         held;
      full = (W+1)'(ta) + (W+1)'(tb_v) + (W+1)'(tc);
      start = 1'b1;
      a     = ta;
      b     = tb_v;
      cin   = tc;
      tick();
      start = 1'b0;
      a     = W'($urandom);
      b     = W'($urandom);
      cin   = 1'($urandom);
      lat     = 0;
      busy_ok = 1'b1;
      held    = 1'b1;
      while (done !== 1'b1 && lat < W + 4) begin
         if (busy !== 1'b1) busy_ok = 1'b0;
         if (sum !== m_sum || cout !== m_cout) held = 1'b0;
         if (lat == inject_at) begin
            start = 1'b1;
            a     = W'($urandom);
            b     = W'($urandom);
            cin   = ~tc;
         end else begin
            start = 1'b0;
         end
         tick();
         lat++;
      end
      start = 1'b0;
      check({tag, "_latency"},      lat,        W);
      check({tag, "_busy_cont"},    busy_ok,    1);
      check({tag, "_result_held"},  held,       1);
      check({tag, "_sum"},          sum,        full[W-1:0]);
      check({tag, "_cout"},         cout,       full[W]);
      check({tag, "_busy_in_done"}, busy,       0);
      m_sum  = full[W-1:0];
      m_cout = full[W];
      tick();
      check({tag, "_done_one_cyc"}, {busy, done}, 2'b00);
   endtask

   initial begin
      bit seen_done;
      int ph;
      logic [W:0] bb_full;

      rst_n = 1'b0;
      start = 1'b0;
      a     = '0;
      b     = '0;
      cin   = 1'b0;
      m_sum  = '0;
      m_cout = 1'b0;

      // reset state
      #1;
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_sum",  sum,  0);
      check("rst_cout", cout, 0);
      tick();
      tick();

      // release reset just after an edge; the very next edge must accept start
      rst_n = 1'b1;
      run_add(8'h00, 8'h00, 1'b0, -1, "zero");
      run_add(8'hFF, 8'h01, 1'b0, -1, "ff_p_01");
      run_add(8'hFF, 8'hFF, 1'b1, -1, "ff_p_ff_c");
      run_add(8'h5A, 8'h33, 1'b0, -1, "5a_p_33");

      // start pulse with new operands 3 cycles in must be ignored
      run_add(8'hC3, 8'h4E, 1'b1, 3, "ignore_start");

      // async reset 4 cycles into an addition aborts it and clears the result
      start = 1'b1;
      a     = 8'h77;
      b     = 8'h11;
      cin   = 1'b1;
      tick();
      start = 1'b0;
      repeat (4) tick();
      check("pre_abort_busy", busy, 1);
      #2;
      rst_n = 1'b0;
      #1;
      check("abort_busy", busy, 0);
      check("abort_done", done, 0);
      check("abort_sum",  sum,  0);
      check("abort_cout", cout, 0);
      m_sum  = '0;
      m_cout = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
      seen_done = 1'b0;
      for (int i = 0; i < W + 2; i++) begin
         if (done === 1'b1 || busy === 1'b1) seen_done = 1'b1;
         tick();
      end
      check("abort_no_done", seen_done, 0);
      check("abort_sum_stays", sum, 0);
      run_add(8'h10, 8'h20, 1'b0, -1, "post_abort");

      // start held high for 20 edges: two additions, one idle cycle between done and busy
      bb_full = (W+1)'(8'hA7) + (W+1)'(8'h6C);
      start = 1'b1;
      a     = 8'hA7;
      b     = 8'h6C;
      cin   = 1'b0;
      tick();
      for (int k = 0; k < 20; k++) begin
         ph = k % (W + 2);
         check($sformatf("b2b_bd_k%0d", k), {busy, done}, {(ph < W), (ph == W)});
         if (ph == W) begin
            check($sformatf("b2b_sum_k%0d", k), {cout, sum}, bb_full);
         end
         if (k == 19) start = 1'b0;
         tick();
      end
      m_sum  = bb_full[W-1:0];
      m_cout = bb_full[W];
      check("b2b_stops", {busy, done}, 2'b00);

      // random operands, some with an interfering start pulse mid-addition
      for (int n = 0; n < 12; n++) begin
         run_add(W'($urandom), W'($urandom), 1'($urandom),
                 ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, W - 2)) : -1,
                 $sformatf("rand%0d", n));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
